dec_key_sched: RTL and testbench



---
 rtl/dec_key_sched_pkg.sv | 23 ++
 rtl/dec_key_sched_word_invmix.sv | 35 +++
 rtl/dec_key_sched.sv | 112 +++++++++++
 tb/tb_dec_key_sched.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dec_key_sched_pkg.sv
// Shared AES definitions: round counts, GF(2^8) reduction constant, xtime,
// and the state encoding of the decryption key sequencer.
package dec_key_sched_pkg;

  localparam int NR_128 = 10;
  localparam int NR_192 = 12;
  localparam int NR_256 = 14;

  // Low byte of the field modulus x^8+x^4+x^3+x+1.
  localparam logic [7:0] GF_RED = 8'h1B;

  // Width of wr/rd counters and of the dk_round index (covers NR up to 14).
  localparam int CNT_W = 4;

  localparam logic ST_LOAD  = 1'b0;
  localparam logic ST_DRAIN = 1'b1;

  // Multiply a field element by 02.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? GF_RED : 8'h00);
  endfunction

endpackage

// File: rtl/dec_key_sched_word_invmix.sv
// InvMixColumns on a single 32-bit column {a,b,c,d}, a in bits [31:24].
// Purely combinational; products by 09/0b/0d/0e are built from 02/04/08.
module word_invmix
  import dec_key_sched_pkg::*;
(
  input  logic [31:0] col_i,
  output logic [31:0] col_o
);

  logic [7:0] byte_in [4];
  logic [7:0] x2 [4];
  logic [7:0] x4 [4];
  logic [7:0] x8 [4];
  logic [7:0] m9 [4];
  logic [7:0] mb [4];
  logic [7:0] md [4];
  logic [7:0] me [4];

  for (genvar j = 0; j < 4; j++) begin : g_byte
    assign byte_in[j] = col_i[31-8*j -: 8];
    assign x2[j]      = xtime(byte_in[j]);
    assign x4[j]      = xtime(x2[j]);
    assign x8[j]      = xtime(x4[j]);
    assign m9[j]      = x8[j] ^ byte_in[j];
    assign mb[j]      = x8[j] ^ x2[j] ^ byte_in[j];
    assign md[j]      = x8[j] ^ x4[j] ^ byte_in[j];
    assign me[j]      = x8[j] ^ x4[j] ^ x2[j];
  end

  // Output byte j sees its own byte times 0e, then 0b, 0d, 09 rotating right.
  for (genvar j = 0; j < 4; j++) begin : g_out
    assign col_o[31-8*j -: 8] = me[j] ^ mb[(j+1)%4] ^ md[(j+2)%4] ^ m9[(j+3)%4];
  end

endmodule

// File: rtl/dec_key_sched.sv
// Decryption round-key sequencer for the equivalent inverse cipher.
// Buffers ek[0..NR] in LOAD, then replays them in reverse in DRAIN,
// applying InvMixColumns to every key except dk[0] and dk[NR].
module dec_key_sched
  import dec_key_sched_pkg::*;
#(
  parameter int NR = NR_128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [127:0]     ek_in,
  input  logic             ek_valid,
  output logic             ek_ready,
  output logic [127:0]     dk_out,
  output logic [CNT_W-1:0] dk_round,
  output logic             dk_valid,
  input  logic             dk_ready,
  output logic             busy
);

  localparam logic [CNT_W-1:0] NR_C = CNT_W'(NR);

  logic             state_q, state_d;
  logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
  logic [127:0]     slot_q [NR+1];

  logic             ek_fire;
  logic             dk_fire;
  logic [CNT_W-1:0] rd_idx;
  logic [127:0]     src;
  logic [127:0]     mixed;
  logic             bypass;

  assign ek_ready = (state_q == ST_LOAD);
  assign dk_valid = (state_q == ST_DRAIN);
  assign ek_fire  = ek_valid & ek_ready;
  assign dk_fire  = dk_valid & dk_ready;
  assign busy     = !((state_q == ST_LOAD) && (wr_cnt_q == '0));

  // Next-state and counter logic; flush overrides any handshake this cycle.
  always_comb begin
    state_d  = state_q;
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    if (flush) begin
      state_d  = ST_LOAD;
      wr_cnt_d = '0;
      rd_cnt_d = '0;
    end else if (state_q == ST_LOAD) begin
      if (ek_fire) begin
        if (wr_cnt_q == NR_C) begin
          state_d  = ST_DRAIN;
          wr_cnt_d = '0;
          rd_cnt_d = '0;
        end else begin
          wr_cnt_d = wr_cnt_q + 1'b1;
        end
      end
    end else begin
      if (dk_fire) begin
        if (rd_cnt_q == NR_C) begin
          state_d  = ST_LOAD;
          wr_cnt_d = '0;
          rd_cnt_d = '0;
        end else begin
          rd_cnt_d = rd_cnt_q + 1'b1;
        end
      end
    end
  end

  // Control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_LOAD;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
    end
  end

  // Key storage: cleared only by rst; a key arriving with flush is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k <= NR; k++) slot_q[k] <= '0;
    end else if (ek_fire && !flush) begin
      slot_q[wr_cnt_q] <= ek_in;
    end
  end

  // Reverse-order read path.
  assign rd_idx = NR_C - rd_cnt_q;
  assign src    = slot_q[rd_idx];

  for (genvar k = 0; k < 4; k++) begin : g_col
    word_invmix u_invmix (
      .col_i (src[127-32*k -: 32]),
      .col_o (mixed[127-32*k -: 32])
    );
  end

  // First and last decryption keys pass through untransformed.
  assign bypass   = (rd_cnt_q == '0) || (rd_cnt_q == NR_C);
  assign dk_out   = dk_valid ? (bypass ? src : mixed) : '0;
  assign dk_round = dk_valid ? rd_cnt_q : '0;

endmodule

// File: tb/tb_dec_key_sched.sv
// Bench for dec_key_sched: NR=10 and NR=14 instances share one stimulus set;
// a reference model (S-box, key expansion, InvMixColumns) fills a scoreboard.
module tb_dec_key_sched;

  logic         clk;
  logic         rst;
  logic         flush;
  logic [127:0] ek_in;
  logic         ek_valid;
  logic         dk_ready;

  logic         ek_ready10, dk_valid10, busy10;
  logic [127:0] dk_out10;
  logic [3:0]   dk_round10;
  logic         ek_ready14, dk_valid14, busy14;
  logic [127:0] dk_out14;
  logic [3:0]   dk_round14;

  logic         sel14;
  logic         o_ready, o_valid, o_busy;
  logic [127:0] o_dk;
  logic [3:0]   o_round;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]   rnd;
    logic [127:0] key;
  } sb_t;
  sb_t sb[$];

  logic [127:0] ek_arr   [15];
  logic [127:0] captured [15];

  dec_key_sched #(.NR(10)) u_dut10 (
    .clk(clk), .rst(rst), .flush(flush),
    .ek_in(ek_in), .ek_valid(ek_valid), .ek_ready(ek_ready10),
    .dk_out(dk_out10), .dk_round(dk_round10), .dk_valid(dk_valid10),
    .dk_ready(dk_ready), .busy(busy10)
  );

  dec_key_sched #(.NR(14)) u_dut14 (
    .clk(clk), .rst(rst), .flush(flush),
    .ek_in(ek_in), .ek_valid(ek_valid), .ek_ready(ek_ready14),
    .dk_out(dk_out14), .dk_round(dk_round14), .dk_valid(dk_valid14),
    .dk_ready(dk_ready), .busy(busy14)
  );

  always_comb begin
    o_ready = sel14 ? ek_ready14 : ek_ready10;
    o_valid = sel14 ? dk_valid14 : dk_valid10;
    o_busy  = sel14 ? busy14     : busy10;
    o_dk    = sel14 ? dk_out14   : dk_out10;
    o_round = sel14 ? dk_round14 : dk_round10;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b);
    logic [7:0] a;
    logic [7:0] p;
    a = a_in;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [7:0] r;
    r = b;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv;
    logic [7:0] base;
    inv  = 8'h01;
    base = x;
    for (int i = 0; i < 8; i++) begin
      if (i != 0) inv = gmul(inv, base);  // exponent 254 = 0b11111110
      base = gmul(base, base);
    end
    if (x == 8'h00) inv = 8'h00;
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic void expand(input logic [255:0] key, input int nk, input int nr);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = subword(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++) ek_arr[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  function automatic logic [127:0] invmix_model(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a, b, c, d;
    for (int k = 0; k < 4; k++) begin
      a = s[127-32*k -: 8];
      b = s[119-32*k -: 8];
      c = s[111-32*k -: 8];
      d = s[103-32*k -: 8];
      o[127-32*k -: 8] = gmul(a, 8'h0e) ^ gmul(b, 8'h0b) ^ gmul(c, 8'h0d) ^ gmul(d, 8'h09);
      o[119-32*k -: 8] = gmul(b, 8'h0e) ^ gmul(c, 8'h0b) ^ gmul(d, 8'h0d) ^ gmul(a, 8'h09);
      o[111-32*k -: 8] = gmul(c, 8'h0e) ^ gmul(d, 8'h0b) ^ gmul(a, 8'h0d) ^ gmul(b, 8'h09);
      o[103-32*k -: 8] = gmul(d, 8'h0e) ^ gmul(a, 8'h0b) ^ gmul(b, 8'h0d) ^ gmul(c, 8'h09);
    end
    return o;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_expected(input int nr);
    sb_t e;
    for (int i = 0; i <= nr; i++) begin
      e.rnd = 4'(i);
      if (i == 0)       e.key = ek_arr[nr];
      else if (i == nr) e.key = ek_arr[0];
      else              e.key = invmix_model(ek_arr[nr-i]);
      sb.push_back(e);
    end
  endtask

  task automatic load(input int n, input bit rnd);
    int i;
    int budget;
    bit v;
    i = 0;
    budget = 0;
    while (i < n && budget < 400) begin
      v = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      ek_valid = v;
      ek_in = v ? ek_arr[i] : {$urandom, $urandom, $urandom, $urandom};
      chk("ek_ready_in_load", 128'(o_ready), 128'(1));
      @(posedge clk); #1;
      if (v) i++;
      budget++;
    end
    ek_valid = 1'b0;
    ek_in = '0;
    chk("load_done_in_budget", 128'(i), 128'(n));
  endtask

  task automatic drain(input int n, input bit rnd);
    int got;
    int budget;
    bit first;
    got = 0;
    budget = 0;
    first = 1'b1;
    while (got < n && budget < 400) begin
      dk_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (first) begin
        chk("first_dk_valid", 128'(o_valid), 128'(1));
        chk("ek_ready_in_drain", 128'(o_ready), 128'(0));
        first = 1'b0;
      end
      if (o_valid) begin
        if (sb.size() == 0) begin
          chk("scoreboard_nonempty", 128'(0), 128'(1));
        end else begin
          chk("dk_out", o_dk, sb[0].key);
          chk("dk_round", 128'(o_round), 128'(sb[0].rnd));
          if (dk_ready) begin
            void'(sb.pop_front());
            captured[got] = o_dk;
            got++;
          end
        end
      end
      @(posedge clk); #1;
      budget++;
    end
    dk_ready = 1'b0;
    chk("drain_done_in_budget", 128'(got), 128'(n));
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_ek_ready"}, 128'(o_ready), 128'(1));
    chk({tag, "_dk_valid"}, 128'(o_valid), 128'(0));
    chk({tag, "_busy"},     128'(o_busy),  128'(0));
    chk({tag, "_dk_out"},   o_dk,          128'(0));
    chk({tag, "_dk_round"}, 128'(o_round), 128'(0));
  endtask

  task automatic random_keys(input int nr);
    for (int k = 0; k <= nr; k++) ek_arr[k] = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    sel14    = 1'b0;
    rst      = 1'b1;
    flush    = 1'b0;
    ek_in    = '0;
    ek_valid = 1'b0;
    dk_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_idle("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // FIPS-197 AES-128 schedule
    expand({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4, 10);
    load(11, 1'b0);
    push_expected(10);
    drain(11, 1'b0);
    chk("fips128_dk0",  captured[0],  128'h13111d7fe3944a17f307a78b4d2b30c5);
    chk("fips128_dk1",  captured[1],  128'h13aa29be9c8faff6f770f58000f7bf03);
    chk("fips128_dk10", captured[10], 128'h000102030405060708090a0b0c0d0e0f);
    check_idle("after_drain128");

    // InvMixColumns identity on 0x01 columns
    for (int k = 0; k <= 10; k++) ek_arr[k] = {16{8'h01}};
    load(11, 1'b0);
    push_expected(10);
    drain(11, 1'b0);

    // Indexed keys ek[k] = {16{k}}: checks reversal and bypass
    for (int k = 0; k <= 10; k++) ek_arr[k] = {16{8'(k)}};
    load(11, 1'b0);
    push_expected(10);
    drain(11, 1'b0);
    chk("indexed_dk0",  captured[0],  {16{8'h0a}});
    chk("indexed_dk8",  captured[8],  {16{8'h02}});
    chk("indexed_dk10", captured[10], {16{8'h00}});

    // Backpressure on both sides
    random_keys(10);
    load(11, 1'b1);
    push_expected(10);
    drain(11, 1'b1);

    // flush after 5 keys; the key presented with flush is dropped
    random_keys(10);
    load(5, 1'b0);
    flush = 1'b1;
    ek_valid = 1'b1;
    ek_in = {4{32'hdeadbeef}};
    @(posedge clk); #1;
    flush = 1'b0;
    ek_valid = 1'b0;
    check_idle("flush_load");
    random_keys(10);
    load(11, 1'b0);
    push_expected(10);
    drain(11, 1'b0);

    // flush at dk_round=3
    random_keys(10);
    load(11, 1'b0);
    push_expected(10);
    drain(3, 1'b0);
    chk("round_before_flush", 128'(o_round), 128'(3));
    flush = 1'b1;
    dk_ready = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    dk_ready = 1'b0;
    sb.delete();
    check_idle("flush_drain");
    random_keys(10);
    load(11, 1'b1);
    push_expected(10);
    drain(11, 1'b0);

    // rst at dk_round=4, then a zero load
    random_keys(10);
    load(11, 1'b0);
    push_expected(10);
    drain(4, 1'b0);
    chk("round_before_rst", 128'(o_round), 128'(4));
    rst = 1'b1;
    dk_ready = 1'b1;
    ek_valid = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    dk_ready = 1'b0;
    ek_valid = 1'b0;
    sb.delete();
    check_idle("rst_drain");
    for (int k = 0; k <= 10; k++) ek_arr[k] = '0;
    load(11, 1'b0);
    push_expected(10);
    drain(11, 1'b0);

    // NR=14 with FIPS-197 AES-256 schedule
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sel14 = 1'b1;
    check_idle("reset14");
    expand(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8, 14);
    load(15, 1'b0);
    push_expected(14);
    drain(15, 1'b1);
    chk("aes256_first_unmodified", captured[0],  ek_arr[14]);
    chk("aes256_last_unmodified",  captured[14], ek_arr[0]);
    check_idle("after_drain256");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
